ball_ctrl: RTL and testbench

Ball motion and rally controller for the pong datapath, directly upstream of both paddle instances. On each frame tick it advances the ball's upper-left corner and bounces it off the top and bottom walls. It resolves paddle hits or misses against the current paddle Y positions and serves the ball from centre after each point. Its ball_x, ball_y and ball_direction outputs feed the paddle AI inputs. Its score pulses feed the score counters.

---
 rtl/ball_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_ball_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Ball motion and rally controller: advances the ball on each frame tick,
// bounces it off the walls and paddles, scores misses and re-serves.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   tick              one-cycle frame strobe; motion advances only on it
//   width             paddle width (px)
//   wall_width        top/bottom wall thickness (px)
//   ball_width        ball side length (px)
//   length            paddle length (px)
//   left_y, right_y   paddle top Y positions
//   ball_x, ball_y    ball upper-left corner
//   ball_direction    1 = moving left, 0 = moving right
//   in_play           high while the rally is live
//   score_left/right  one-cycle point pulses
module ball_ctrl #(
    parameter int SERVE_TICKS      = 60,
    parameter int DX_INIT          = 2,
    parameter int DX_MAX           = 6,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int DY_EDGE          = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [5:0] width,
    input  logic [5:0] wall_width,
    input  logic [5:0] ball_width,
    input  logic [8:0] length,
    input  logic [8:0] left_y,
    input  logic [8:0] right_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       ball_direction,
    output logic       in_play,
    output logic       score_left,
    output logic       score_right
);

    typedef enum logic {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        dir_q, dir_d;
    // 1 = moving up
    logic        diry_q, diry_d;
    logic [7:0]  dx_q, dx_d;
    logic [7:0]  dy_q, dy_d;
    logic [7:0]  hit_q, hit_d;
    logic [15:0] serve_q, serve_d;
    logic        sl_q, sl_d;
    logic        sr_q, sr_d;

    // All geometry is widened to 11 bits so subtractions cannot wrap
    logic [10:0] w, ww, bw, len, bx, by, dx11, dy11, py, quarter;
    logic signed [10:0] off;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic        top_hit, bot_hit;
    logic        edge_l, edge_r, at_edge, overlap;
    logic        off_hi, off_lo;
    logic [7:0]  hit_inc;

    assign w       = {5'b0, width};
    assign ww      = {5'b0, wall_width};
    assign bw      = {5'b0, ball_width};
    assign len     = {2'b0, length};
    assign bx      = {1'b0, x_q};
    assign by      = {2'b0, y_q};
    assign dx11    = {3'b0, dx_q};
    assign dy11    = {3'b0, dy_q};
    assign py      = {2'b0, (dir_q ? left_y : right_y)};
    assign quarter = len >> 2;

    assign cx = 10'((11'd640 - bw) >> 1);
    assign cy = 9'((11'd480 - bw) >> 1);

    assign top_hit = by < (ww + dy11);
    assign bot_hit = (by + bw + dy11) > (11'd480 - ww);
    assign edge_l  = bx < (w + dx11);
    assign edge_r  = (bx + bw + dx11) > (11'd640 - w);
    assign at_edge = dir_q ? edge_l : edge_r;
    assign overlap = ((by + bw) > py) && (by < (py + len));

    // Hit offset of the ball centre below the paddle top, signed
    assign off    = $signed(by + (bw >> 1) - py);
    assign off_hi = off < $signed(quarter);
    assign off_lo = off >= $signed(len - quarter);

    assign hit_inc = hit_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SERVE;
            x_q     <= cx;
            y_q     <= cy;
            dir_q   <= 1'b1;
            diry_q  <= 1'b1;
            dx_q    <= 8'(DX_INIT);
            dy_q    <= 8'd1;
            hit_q   <= 8'd0;
            serve_q <= 16'(SERVE_TICKS);
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            diry_q  <= diry_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            hit_q   <= hit_d;
            serve_q <= serve_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        diry_d  = diry_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hit_d   = hit_q;
        serve_d = serve_q;
        sl_d    = 1'b0;
        sr_d    = 1'b0;

        unique case (state_q)
            SERVE: begin
                x_d = cx;
                y_d = cy;
                // A count of 0 or 1 both release on this tick
                if (tick) begin
                    if (serve_q <= 16'd1) begin
                        state_d = PLAY;
                    end else begin
                        serve_d = serve_q - 16'd1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    if (diry_q) begin
                        if (top_hit) begin
                            y_d    = 9'(ww);
                            diry_d = 1'b0;
                        end else begin
                            y_d = 9'(by - dy11);
                        end
                    end else begin
                        if (bot_hit) begin
                            y_d    = 9'(11'd480 - ww - bw);
                            diry_d = 1'b1;
                        end else begin
                            y_d = 9'(by + dy11);
                        end
                    end

                    if (!at_edge) begin
                        x_d = dir_q ? 10'(bx - dx11)
                                    : 10'(bx + dx11);
                    end else if (overlap) begin
                        x_d   = dir_q ? 10'(w)
                                      : 10'(11'd640 - w - bw);
                        dir_d = ~dir_q;
                        // Paddle deflection overrides the wall result
                        if (off_hi) begin
                            dy_d   = 8'(DY_EDGE);
                            diry_d = 1'b1;
                        end else if (off_lo) begin
                            dy_d   = 8'(DY_EDGE);
                            diry_d = 1'b0;
                        end else begin
                            dy_d = 8'd1;
                        end
                        if (hit_inc >= 8'(HITS_PER_SPEEDUP)) begin
                            hit_d = 8'd0;
                            if (dx_q >= 8'(DX_MAX)) begin
                                dx_d = 8'(DX_MAX);
                            end else begin
                                dx_d = dx_q + 8'd1;
                            end
                        end else begin
                            hit_d = hit_inc;
                        end
                    end else begin
                        // Miss: direction already points at the
                        // conceding side, so it is left unchanged
                        sr_d    = dir_q;
                        sl_d    = ~dir_q;
                        state_d = SERVE;
                        x_d     = cx;
                        y_d     = cy;
                        serve_d = 16'(SERVE_TICKS);
                        dx_d    = 8'(DX_INIT);
                        dy_d    = 8'd1;
                        hit_d   = 8'd0;
                        diry_d  = ~diry_q;
                    end
                end
            end
        endcase
    end

    assign ball_x         = x_q;
    assign ball_y         = y_q;
    assign ball_direction = dir_q;
    assign in_play        = (state_q == PLAY);
    assign score_left     = sl_q;
    assign score_right    = sr_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: a reference model predicts every
// cycle's outputs, queued at stimulus time and compared after the edge.
module tb_ball_ctrl;

    localparam int SERVE_TICKS = 60;
    localparam int DX_INIT     = 2;
    localparam int DX_MAX      = 6;
    localparam int HITS        = 4;
    localparam int DY_EDGE     = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [5:0] width, wall_width, ball_width;
    logic [8:0] length, left_y, right_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_direction, in_play, score_left, score_right;

    ball_ctrl #(
        .SERVE_TICKS(SERVE_TICKS),
        .DX_INIT(DX_INIT),
        .DX_MAX(DX_MAX),
        .HITS_PER_SPEEDUP(HITS),
        .DY_EDGE(DY_EDGE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .width(width),
        .wall_width(wall_width),
        .ball_width(ball_width),
        .length(length),
        .left_y(left_y),
        .right_y(right_y),
        .ball_x(ball_x),
        .ball_y(ball_y),
        .ball_direction(ball_direction),
        .in_play(in_play),
        .score_left(score_left),
        .score_right(score_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int dir;
        int play;
        int sl;
        int sr;
    } exp_t;

    typedef struct {
        int cycles;
        int lmode;
        int lval;
        int rmode;
        int rval;
    } phase_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    // Reference model state
    int m_play, mx, my, m_dir, m_up, m_dx, m_dy, m_hit, m_serve;
    int m_sl, m_sr;
    int max_dx_seen;
    int sr_seen;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_play  = 0;
        mx      = (640 - ball_width) / 2;
        my      = (480 - ball_width) / 2;
        m_dir   = 1;
        m_up    = 1;
        m_dx    = DX_INIT;
        m_dy    = 1;
        m_hit   = 0;
        m_serve = SERVE_TICKS;
        m_sl    = 0;
        m_sr    = 0;
    endtask

    task automatic model_tick(input int ly, input int ry);
        int w, ww, bw, ln, ny, nup, py, off;
        bit at_edge;
        w  = width;
        ww = wall_width;
        bw = ball_width;
        ln = length;
        ny  = my;
        nup = m_up;
        if (m_up == 1) begin
            if (my < ww + m_dy) begin
                ny  = ww;
                nup = 0;
            end else begin
                ny = my - m_dy;
            end
        end else begin
            if (my + bw + m_dy > 480 - ww) begin
                ny  = 480 - ww - bw;
                nup = 1;
            end else begin
                ny = my + m_dy;
            end
        end
        py = (m_dir == 1) ? ly : ry;
        if (m_dir == 1) at_edge = (mx < w + m_dx);
        else at_edge = (mx + bw + m_dx > 640 - w);
        if (!at_edge) begin
            mx   = (m_dir == 1) ? mx - m_dx : mx + m_dx;
            my   = ny;
            m_up = nup;
        end else if ((my + bw > py) && (my < py + ln)) begin
            off  = my + bw / 2 - py;
            mx   = (m_dir == 1) ? w : 640 - w - bw;
            m_dir = 1 - m_dir;
            my   = ny;
            m_up = nup;
            if (off < ln / 4) begin
                m_dy = DY_EDGE;
                m_up = 1;
            end else if (off >= ln - ln / 4) begin
                m_dy = DY_EDGE;
                m_up = 0;
            end else begin
                m_dy = 1;
            end
            m_hit = m_hit + 1;
            if (m_hit == HITS) begin
                m_hit = 0;
                if (m_dx < DX_MAX) m_dx = m_dx + 1;
            end
            if (m_dx > max_dx_seen) max_dx_seen = m_dx;
        end else begin
            if (m_dir == 1) m_sr = 1;
            else m_sl = 1;
            m_play  = 0;
            mx      = (640 - bw) / 2;
            my      = (480 - bw) / 2;
            m_serve = SERVE_TICKS;
            m_dx    = DX_INIT;
            m_dy    = 1;
            m_hit   = 0;
            m_up    = 1 - m_up;
        end
    endtask

    task automatic model_step(input bit rst, input bit tk,
                              input int ly, input int ry);
        if (rst) begin
            model_reset();
        end else begin
            m_sl = 0;
            m_sr = 0;
            if (m_play == 0) begin
                mx = (640 - ball_width) / 2;
                my = (480 - ball_width) / 2;
                if (tk) begin
                    if (m_serve <= 1) m_play = 1;
                    else m_serve = m_serve - 1;
                end
            end else if (tk) begin
                model_tick(ly, ry);
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit tk);
        exp_t e, g;
        reset = rst;
        tick  = tk;
        model_step(rst, tk, int'(left_y), int'(right_y));
        e.x = mx; e.y = my; e.dir = m_dir; e.play = m_play;
        e.sl = m_sl; e.sr = m_sr;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        g.x = int'(ball_x); g.y = int'(ball_y);
        g.dir = int'(ball_direction); g.play = int'(in_play);
        g.sl = int'(score_left); g.sr = int'(score_right);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL step%0d got x=%0d y=%0d dir=%0d play=%0d sl=%0d sr=%0d want x=%0d y=%0d dir=%0d play=%0d sl=%0d sr=%0d",
                     step, g.x, g.y, g.dir, g.play, g.sl, g.sr,
                     e.x, e.y, e.dir, e.play, e.sl, e.sr);
        end
        step++;
    endtask

    task automatic check_val(input string name, input int got,
                             input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_reset_vals(input string tag, input int cx,
                                    input int cy);
        check_val({tag, "_x"}, int'(ball_x), cx);
        check_val({tag, "_y"}, int'(ball_y), cy);
        check_val({tag, "_dir"}, int'(ball_direction), 1);
        check_val({tag, "_play"}, int'(in_play), 0);
        check_val({tag, "_sl"}, int'(score_left), 0);
        check_val({tag, "_sr"}, int'(score_right), 0);
    endtask

    function automatic int paddle(input int mode, input int val);
        if (mode == 0) return val;
        return clampi(my + int'(ball_width) / 2 - val, 0, 511);
    endfunction

    task automatic run_phase(input phase_t p);
        for (int i = 0; i < p.cycles; i++) begin
            left_y  = 9'(paddle(p.lmode, p.lval));
            right_y = 9'(paddle(p.rmode, p.rval));
            cycle(1'b0, $urandom_range(0, 3) != 0);
            if (score_right && sr_seen == 0) begin
                sr_seen = 1;
                check_val("miss_x", int'(ball_x), 316);
                check_val("miss_y", int'(ball_y), 236);
                check_val("miss_dir", int'(ball_direction), 1);
                check_val("miss_play", int'(in_play), 0);
            end
        end
    endtask

    phase_t ph[6];

    initial begin
        // mode 0: fixed Y; mode 1: tracks ball with given hit offset
        ph[0] = '{5200, 1, 36, 1, 30};
        ph[1] = '{900, 1, 3, 1, 2};
        ph[2] = '{900, 1, 60, 1, 62};
        ph[3] = '{1800, 0, 400, 1, 32};
        ph[4] = '{1800, 1, 20, 0, 0};
        ph[5] = '{2000, 1, 10, 1, 35};

        max_dx_seen = 0;
        sr_seen     = 0;
        width       = 6'd8;
        wall_width  = 6'd8;
        ball_width  = 6'd8;
        length      = 9'd64;
        left_y      = 9'd208;
        right_y     = 9'd208;
        reset       = 1'b1;
        tick        = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0);
        check_reset_vals("rst", 316, 236);

        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b1);
        check_val("serve59_play", int'(in_play), 0);
        cycle(1'b0, 1'b0);
        check_val("idle_play", int'(in_play), 0);
        cycle(1'b0, 1'b1);
        check_val("serve60_play", int'(in_play), 1);
        check_val("serve60_x", int'(ball_x), 316);
        cycle(1'b0, 1'b1);
        check_val("first_x", int'(ball_x), 314);
        check_val("first_y", int'(ball_y), 235);
        cycle(1'b0, 1'b0);
        check_val("notick_x", int'(ball_x), 314);

        run_phase(ph[0]);
        check_val("dx_cap", max_dx_seen, DX_MAX);
        cycle(1'b1, 1'b1);
        check_reset_vals("midrst", 316, 236);

        for (int p = 1; p < 5; p++) run_phase(ph[p]);

        width      = 6'd10;
        wall_width = 6'd4;
        ball_width = 6'd6;
        length     = 9'd40;
        cycle(1'b1, 1'b0);
        check_reset_vals("rst2", 317, 237);
        run_phase(ph[5]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
